fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 Port clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port imem_req_valid  out  1  instruction-memory request valid.
REQ-005 Port imem_req_ready  in  1  memory accepts the request this cycle.
REQ-006 Port imem_addr  out  32  request address, word aligned.
REQ-007 Port imem_rsp_valid  in  1  response data valid; one response per accepted request, in order, at least 1 cycle after acceptance.
REQ-008 Port imem_rsp_data  in  32  fetched instruction word.
REQ-009 Port redirect_valid  in  1  branch/jump redirect from the branch target unit.
REQ-010 Port redirect_pc  in  32  redirect target address.
REQ-011 Port if_valid  out  1  instruction to decode valid.
REQ-012 Port if_ready  in  1  decode accepts the instruction.
REQ-013 Port if_pc  out  32  address of the presented instruction.
REQ-014 Port if_instr  out  32  presented instruction word.

Function
REQ-015 States REQ, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-016 REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready -> WAIT.
REQ-017 imem_addr and imem_req_valid stable while imem_req_valid=1 and imem_req_ready=0, unless a redirect occurs.
REQ-018 WAIT: on imem_rsp_valid capture if_pc<=pc, if_instr<=imem_rsp_data, if_valid<=1, pc<=next_pc -> HOLD.
REQ-019 next_pc = pc+4, 32-bit modulo wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 HOLD: if_valid=1, if_pc/if_instr stable; on if_ready, if_valid<=0 -> REQ; no request issued in HOLD.
REQ-021 Latency with zero-wait memory: request cycle N, response N+1, if_valid N+2.
REQ-022 Redirect has priority over every other event in the same cycle: pc<=redirect_pc with bits [1:0] forced to 0, if_valid<=0.
REQ-023 Redirect in REQ without imem_req_ready -> REQ; with imem_req_ready in same cycle -> DROP.
REQ-024 Redirect in WAIT without imem_rsp_valid -> DROP; with imem_rsp_valid in same cycle -> data discarded, -> REQ.
REQ-025 Redirect in HOLD (including with if_ready) -> REQ; held instruction discarded.
REQ-026 Redirect in DROP without imem_rsp_valid -> DROP with new pc; with imem_rsp_valid -> REQ with new pc.
REQ-027 DROP: imem_req_valid=0; on imem_rsp_valid discard data, if_valid stays 0, -> REQ.

Reset
REQ-028 On rst_n low, asynchronously: state=REQ, pc=RESET_PC, imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0.
REQ-029 imem_req_valid first asserts on the first rising edge after rst_n deasserts; reset mid-transaction abandons any outstanding response, which the memory side is also reset to drop.

Configuration
REQ-030 Macro FETCH_JAL_PREDICT_EN: when defined, a captured word with opcode [6:0]=7'b1101111 sets next_pc = pc + sign-extended J-immediate (bits {31,19:12,20,30:21,1'b0}).
REQ-031 Without FETCH_JAL_PREDICT_EN, next_pc = pc+4 for every instruction; a later redirect still corrects control flow.

Verification
REQ-032 Reset, RESET_PC=32'h100, zero-wait memory, if_ready=1 -> imem_addr 0x100, 0x104, 0x108; if_pc matches; if_valid 2 cycles after each request.
REQ-033 imem_req_ready held 0 for 3 cycles at address 0x104 -> imem_addr stable at 0x104; no if_valid pulse.
REQ-034 if_ready=0 for 4 cycles in HOLD -> if_pc/if_instr stable; no new request; resume on if_ready=1.
REQ-035 Redirect to 0x203 while in WAIT -> next response dropped, if_valid stays 0, next request at 0x200.
REQ-036 Redirect and imem_rsp_valid in the same cycle in WAIT -> data discarded, request at redirect target next cycle.
REQ-037 With FETCH_JAL_PREDICT_EN, word 32'h0080006F at 0x100 -> next request at 0x108; without the macro -> 0x104.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect input and decode-side output.
// The master modport is the fetch unit's view; the slave modport is the memory/decode/branch environment.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher (REQ/WAIT/HOLD/DROP); optional JAL prediction under FETCH_JAL_PREDICT_EN.
// Latency: request accepted in cycle N, response N+1, if_valid N+2 with a zero-wait memory.
// Backpressure: request held stable until imem_req_ready; instruction held until if_ready; redirect overrides all.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req_vld;
  logic        out_vld;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] next_pc;
  logic [31:0] redirect_tgt;
  logic        req_fire;

  assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
  assign req_fire     = req_vld && bus.imem_req_ready;

`ifdef FETCH_JAL_PREDICT_EN
  logic [31:0] j_imm;
  assign j_imm   = {{12{bus.imem_rsp_data[31]}}, bus.imem_rsp_data[19:12], bus.imem_rsp_data[20],
                    bus.imem_rsp_data[30:21], 1'b0};
  assign next_pc = (bus.imem_rsp_data[6:0] == 7'b1101111) ? pc + j_imm : pc + 32'd4;
`else
  assign next_pc = pc + 32'd4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      req_vld   <= 1'b0;
      out_vld   <= 1'b0;
      out_pc    <= 32'h0;
      out_instr <= 32'h0;
    end else if (bus.redirect_valid) begin
      // A request already accepted, or a response not yet returned, must be drained in DROP.
      pc      <= redirect_tgt;
      out_vld <= 1'b0;
      case (state)
        S_REQ: begin
          state   <= req_fire ? S_DROP : S_REQ;
          req_vld <= !req_fire;
        end
        S_WAIT, S_DROP: begin
          state   <= bus.imem_rsp_valid ? S_REQ : S_DROP;
          req_vld <= bus.imem_rsp_valid;
        end
        default: begin
          state   <= S_REQ;
          req_vld <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        S_REQ: begin
          // req_vld is low only in the first cycle after reset.
          if (req_fire) begin
            state   <= S_WAIT;
            req_vld <= 1'b0;
          end else begin
            req_vld <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            out_pc    <= pc;
            out_instr <= bus.imem_rsp_data;
            out_vld   <= 1'b1;
            pc        <= next_pc;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.if_ready) begin
            out_vld <= 1'b0;
            req_vld <= 1'b1;
            state   <= S_REQ;
          end
        end
        default: begin
          if (bus.imem_rsp_valid) begin
            req_vld <= 1'b1;
            state   <= S_REQ;
          end
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_addr      = pc;
  assign bus.if_valid       = out_vld;
  assign bus.if_pc          = out_pc;
  assign bus.if_instr       = out_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing sequences, a table of single-fetch vectors, and a randomized run
// scored against an instruction-stream model (next instruction = previous + 4, restarted by each redirect).
module tb_fetch_unit;

`ifdef FETCH_JAL_PREDICT_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_img [logic [31:0]];

  // Memory contents: explicit overrides, otherwise a hash with a non-jump opcode.
  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] h;
    if (mem_img.exists(a)) return mem_img[a];
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    return {h[31:7], 7'b0010011};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no event within cycle bound", nm);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!bus.imem_req_valid && n < 20) begin
      nxt();
      n++;
    end
    if (!bus.imem_req_valid) tmo(nm);
  endtask

  task automatic wait_ifv(input string nm);
    int n = 0;
    while (!bus.if_valid && n < 20) begin
      nxt();
      n++;
    end
    if (!bus.if_valid) tmo(nm);
  endtask

  // Memory model: one response per accepted request after lat_min..lat_max extra cycles.
  int          lat_min = 0;
  int          lat_max = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_wait = 0;
  logic        m_acc;
  logic [31:0] m_addr;
  logic        m_taken;

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      m_acc   = rst_n && bus.imem_req_valid && bus.imem_req_ready;
      m_addr  = bus.imem_addr;
      m_taken = bus.imem_rsp_valid;
      if (m_acc) chk1("one_outstanding", pend, 1'b0);
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend               = 1'b0;
        bus.imem_rsp_valid = 1'b0;
      end else begin
        if (m_taken) pend = 1'b0;
        if (m_acc) begin
          pend      = 1'b1;
          pend_addr = m_addr;
          pend_wait = $urandom_range(lat_max, lat_min);
        end
        if (pend && pend_wait == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = memword(pend_addr);
        end else begin
          bus.imem_rsp_valid = 1'b0;
          if (pend) pend_wait--;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] start;
    logic [31:0] word;
    logic [31:0] exp_pc;
    logic [31:0] nxt_jal;
    logic [31:0] nxt_seq;
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] exp_pc;
  logic [31:0] tgt;
  bit          model_ok;
  bit          seen_ifv;
  int          since;
  int          delivered;

  initial begin
    tbl[0] = '{32'h0000_0100, 32'h0080_006F, 32'h0000_0100, 32'h0000_0108, 32'h0000_0104};
    tbl[1] = '{32'hFFFF_FFFC, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
    tbl[2] = '{32'h0000_1003, 32'h0000_0013, 32'h0000_1000, 32'h0000_1004, 32'h0000_1004};
    tbl[3] = '{32'h0000_2000, 32'hFF9F_F06F, 32'h0000_2000, 32'h0000_1FF8, 32'h0000_2004};
    tbl[4] = '{32'hFFFF_FFFC, 32'h0080_006F, 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0000};
    tbl[5] = '{32'h7FFF_FFFE, 32'h0000_0013, 32'h7FFF_FFFC, 32'h8000_0000, 32'h8000_0000};

    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b1;
    rst_n              = 1'b0;
    repeat (3) nxt();
    chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk1("rst_if_valid", bus.if_valid, 1'b0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h100);
    rst_n = 1'b1;

    // Zero-wait stream from 0x100; request stall at 0x104; decode stall at 0x108.
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk1("seq_req_valid", bus.imem_req_valid, 1'b1);
      chk("seq_req_addr", bus.imem_addr, 32'h100 + 32'(4 * k));
      chk1("seq_req_no_ifv", bus.if_valid, 1'b0);
      if (k == 1) begin
        repeat (3) begin
          nxt();
          chk1("stall_req_valid", bus.imem_req_valid, 1'b1);
          chk("stall_addr", bus.imem_addr, 32'h104);
          chk1("stall_no_ifv", bus.if_valid, 1'b0);
        end
        bus.imem_req_ready = 1'b1;
      end
      nxt();
      chk1("seq_wait_req", bus.imem_req_valid, 1'b0);
      chk1("seq_wait_ifv", bus.if_valid, 1'b0);
      if (k == 2) bus.if_ready = 1'b0;
      nxt();
      chk1("seq_ifv", bus.if_valid, 1'b1);
      chk("seq_if_pc", bus.if_pc, 32'h100 + 32'(4 * k));
      chk("seq_if_instr", bus.if_instr, memword(32'h100 + 32'(4 * k)));
      if (k == 0) bus.imem_req_ready = 1'b0;
      if (k == 2) begin
        repeat (4) begin
          nxt();
          chk1("hold_ifv", bus.if_valid, 1'b1);
          chk("hold_if_pc", bus.if_pc, 32'h108);
          chk("hold_if_instr", bus.if_instr, memword(32'h108));
          chk1("hold_no_req", bus.imem_req_valid, 1'b0);
        end
        bus.if_ready = 1'b1;
      end
    end
    nxt();
    chk1("resume_req_valid", bus.imem_req_valid, 1'b1);
    chk("resume_addr", bus.imem_addr, 32'h10C);

    // Redirect in WAIT before the response: response dropped, refetch from aligned target.
    lat_min = 2;
    lat_max = 2;
    nxt();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    nxt();
    bus.redirect_valid = 1'b0;
    lat_min = 0;
    lat_max = 0;
    chk1("drop_no_req", bus.imem_req_valid, 1'b0);
    seen_ifv = 1'b0;
    for (int n = 0; n < 10; n++) begin
      nxt();
      if (bus.if_valid) seen_ifv = 1'b1;
      if (bus.imem_req_valid) break;
    end
    chk1("drop_no_ifv", seen_ifv, 1'b0);
    chk1("redir_req_valid", bus.imem_req_valid, 1'b1);
    chk("redir_addr", bus.imem_addr, 32'h200);

    // Redirect coinciding with the response in WAIT.
    nxt();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h400;
    nxt();
    bus.redirect_valid = 1'b0;
    chk1("same_cyc_req_valid", bus.imem_req_valid, 1'b1);
    chk("same_cyc_addr", bus.imem_addr, 32'h400);
    chk1("same_cyc_no_ifv", bus.if_valid, 1'b0);
    nxt();
    nxt();
    chk1("t400_ifv", bus.if_valid, 1'b1);
    chk("t400_if_pc", bus.if_pc, 32'h400);
    // Redirect in HOLD together with if_ready, then redirect in REQ as the request is accepted.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h503;
    nxt();
    chk1("hold_redir_ifv", bus.if_valid, 1'b0);
    chk("hold_redir_addr", bus.imem_addr, 32'h500);
    chk1("hold_redir_req", bus.imem_req_valid, 1'b1);
    bus.redirect_pc = 32'h600;
    nxt();
    bus.redirect_valid = 1'b0;
    chk1("req_redir_drop", bus.imem_req_valid, 1'b0);
    nxt();
    chk1("req_redir_req", bus.imem_req_valid, 1'b1);
    chk("req_redir_addr", bus.imem_addr, 32'h600);
    chk1("req_redir_no_ifv", bus.if_valid, 1'b0);

    // Table of single fetches: start, word, expected pc and next request address.
    for (int i = 0; i < 6; i++) begin
      wait_req("tbl_wait_req");
      bus.imem_req_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = tbl[i].start;
      mem_img[tbl[i].exp_pc] = tbl[i].word;
      nxt();
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      chk1("tbl_req_valid", bus.imem_req_valid, 1'b1);
      chk("tbl_req_addr", bus.imem_addr, tbl[i].exp_pc);
      wait_ifv("tbl_wait_ifv");
      chk("tbl_if_pc", bus.if_pc, tbl[i].exp_pc);
      chk("tbl_if_instr", bus.if_instr, tbl[i].word);
      wait_req("tbl_wait_next");
      chk("tbl_next_addr", bus.imem_addr, JAL_EN ? tbl[i].nxt_jal : tbl[i].nxt_seq);
      mem_img.delete(tbl[i].exp_pc);
    end

    // Asynchronous reset while a response is outstanding.
    lat_min = 3;
    lat_max = 3;
    nxt();
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_req_valid", bus.imem_req_valid, 1'b0);
    chk1("mid_rst_ifv", bus.if_valid, 1'b0);
    chk("mid_rst_if_pc", bus.if_pc, 32'h0);
    chk("mid_rst_if_instr", bus.if_instr, 32'h0);
    chk("mid_rst_addr", bus.imem_addr, 32'h100);
    nxt();
    nxt();
    rst_n   = 1'b1;
    lat_min = 0;
    lat_max = 0;
    nxt();
    chk1("post_rst_req", bus.imem_req_valid, 1'b1);
    chk("post_rst_addr", bus.imem_addr, 32'h100);
    nxt();
    chk1("post_rst_wait_ifv", bus.if_valid, 1'b0);
    nxt();
    chk1("post_rst_ifv", bus.if_valid, 1'b1);
    chk("post_rst_if_pc", bus.if_pc, 32'h100);

    // Randomized run against the instruction-stream model.
    lat_max   = 3;
    model_ok  = 1'b0;
    since     = 0;
    delivered = 0;
    exp_pc    = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      bus.imem_req_ready = ($urandom_range(99) < 70);
      bus.if_ready       = ($urandom_range(99) < 70);
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      bus.redirect_valid = (i == 0) || ($urandom_range(99) < 4);
      bus.redirect_pc    = tgt;
      if (model_ok) begin
        if (bus.imem_req_valid) chk("rand_req_addr", bus.imem_addr, exp_pc);
        if (bus.if_valid) begin
          chk("rand_if_pc", bus.if_pc, exp_pc);
          chk("rand_if_instr", bus.if_instr, memword(exp_pc));
        end
      end
      if (bus.redirect_valid) begin
        exp_pc   = {tgt[31:2], 2'b00};
        model_ok = 1'b1;
        since    = 0;
      end else if (model_ok && bus.if_valid && bus.if_ready) begin
        exp_pc = exp_pc + 32'd4;
        delivered++;
        since = 0;
      end else begin
        since++;
      end
      if (since > 200) begin
        tmo("rand_progress");
        break;
      end
      nxt();
    end
    bus.redirect_valid = 1'b0;
    chk1("rand_delivered", delivered > 50, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
